sqm_ca_engine: RTL
==================

Name: sqm_ca_engine

Overview:
- Multi-cycle, parametrised successor of the combinational square-modulus / cellular-automaton ALU slice.
- Mode 0 computes (b*b) mod a with a sequential restoring-remainder datapath.
- Mode 1 iterates the 4-entry neighbourhood CA rule for a programmable number of generations.
- Sits behind a start/done handshake so wide W does not create a long combinational divider or ripple chain.

Parameters:
- W, 8, width of operand a, CA state and result y (>= 2).
- BW, 4, width of operand b (>= 4; CA rule uses b[3:0]).
- GW, 4, width of generation count gens.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request; accepted only when busy==0
- op  in  1  0 = square-modulus, 1 = cellular automaton
- a  in  W  modulus (op 0) / initial CA state (op 1)
- b  in  BW  operand to square (op 0) / CA rule table (op 1)
- gens  in  GW  CA generation count (ignored for op 0)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, y/err valid
- y  out  W  result, held until next accepted start
- err  out  1  divide-by-zero flag for the last op, held like y

Behaviour:
- Reset: state IDLE; busy=0, done=0, y=0, err=0; all internal registers cleared. Reset mid-operation aborts the op with no done pulse.
- Accept: start && !busy in cycle T captures op, a, b, gens. Inputs are don't-care after T. Start while busy=1 is ignored with no side effects.
- FSM states: IDLE, SQM, CA, DONE.
  - IDLE: on accept go to SQM (op 0, a!=0), CA (op 1, gens!=0), or DONE directly (a==0 for op 0, or gens==0 for op 1).
  - SQM: stays 2*BW cycles, then goes to DONE.
  - CA: stays gens cycles, then goes to DONE.
  - DONE: lasts 1 cycle with done=1, then returns to IDLE.
- busy=1 in SQM and CA, 0 in IDLE and DONE. An accept is legal in the DONE cycle (back-to-back); the DONE->IDLE transition then proceeds as if from IDLE.
- Square-mod:
  - P = b*b, 2*BW bits, unsigned. Remainder register r is W+1 bits, cleared at accept.
  - Each SQM cycle k (k = 0..2BW-1, MSB first): r = {r, P[2BW-1-k]}; if r >= a then r = r - a.
  - y = r[W-1:0]; err=0. done at T+2*BW+1.
- Square-mod, a==0: y=0, err=1, done at T+1.
- CA step, with s the state register loaded with a at accept:
  - For i in 0..W-1: s'[i] = b[{s[(i+1) mod W], s[i]}], where index = 2*s[i+1] + s[i].
  - Wrap-around: bit W-1 uses s[0] as its neighbour.
- CA: one step per CA cycle. After gens steps, y = s and err=0. done at T+gens+1; gens=0 gives y=a at T+1.
- y and err update only in the DONE cycle. Between operations they hold their last values.

Decomposition:
- Shared package sqm_ca_pkg holds:
  - state enum {IDLE, SQM, CA, DONE};
  - constants OP_SQM=1'b0, OP_CA=1'b1;
  - pure function ca_step(state, rule) returning the next W-bit generation.
- One sub-module, sqm_mod_seq: sequential restoring-remainder unit.
  - Ports: clk, rst, load, p, a, step, r.
  - Instantiated once.
  - The FSM drives load/step and counts 2*BW steps.

Test Plan:
- W=8, BW=4: a=10, b=7, op=0, start at T -> busy T+1..T+8; done at T+9, y=9 (49 mod 10), err=0.
- a=255, b=15, op=0 -> y=225 (0xE1) at T+9. Then a=0, b=5, op=0 -> done at T+1, y=0, err=1.
- op=1, a=8'h81, b=4'b0110 (XOR rule), gens=1 -> done at T+2, y=8'h41. With gens=3 from the same inputs -> y equals ca_step applied 3 times (scoreboard model), done at T+4.
- op=1, a=8'h5A, gens=0 -> done at T+1, y=8'h5A. Start re-asserted during busy for a different op -> ignored, original result delivered.
- Back-to-back: new start in the DONE cycle is accepted, and the second result arrives at its own latency with no lost done pulse.
- rst asserted mid-SQM -> next cycle busy=0, done=0, y=0, err=0, no done pulse. A subsequent op completes correctly.

Source files
------------

// File: rtl/sqm_ca_pkg.sv
// sqm_ca_pkg: shared FSM states, op codes and the cellular-automaton step function.
package sqm_ca_pkg;
  typedef enum logic [1:0] {IDLE, SQM, CA, DONE} state_t;
  localparam logic OP_SQM = 1'b0;
  localparam logic OP_CA  = 1'b1;
  localparam int CA_MAXW = 64;
  // Width-generic: only the low w bits are stepped, wrapping bit w-1 onto bit 0.
  function automatic logic [CA_MAXW-1:0] ca_step(input logic [CA_MAXW-1:0] s, input int w, input logic [3:0] rule);
    logic [CA_MAXW-1:0] n;
    n = '0;
    for (int i = 0; i < CA_MAXW; i++)
      if (i < w) n[i] = rule[{s[(i+1)%w], s[i]}];
    return n;
  endfunction
endpackage

// File: rtl/sqm_mod_seq.sv
// sqm_mod_seq: restoring-remainder unit, folds one product bit (MSB first) into r per step.
module sqm_mod_seq #(
  parameter int W  = 8,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [PW-1:0] p,
  input  logic [W-1:0]  a,
  input  logic          step,
  output logic [W-1:0]  r
);
  logic [PW-1:0] r_p;
  logic [W-1:0]  r_rem;
  logic [W:0]    w_t;
  // r stays below a after every step, so only the shifted value needs W+1 bits.
  assign w_t = {r_rem, r_p[PW-1]};
  assign r   = r_rem;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p   <= '0;
      r_rem <= '0;
    end else if (load) begin
      r_p   <= p;
      r_rem <= '0;
    end else if (step) begin
      r_p   <= r_p << 1;
      r_rem <= (w_t >= {1'b0, a}) ? W'(w_t - {1'b0, a}) : w_t[W-1:0];
    end
  end
endmodule

// File: rtl/sqm_ca_engine.sv
// sqm_ca_engine: multi-cycle (b*b) mod a / cellular-automaton engine behind a start/done handshake.
module sqm_ca_engine
  import sqm_ca_pkg::*;
#(
  parameter int W  = 8,
  parameter int BW = 4,
  parameter int GW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic [W-1:0]  a,
  input  logic [BW-1:0] b,
  input  logic [GW-1:0] gens,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  y,
  output logic          err
);
  localparam int PW = 2 * BW;
  localparam int CW = (GW > $clog2(PW)) ? GW : $clog2(PW);
  state_t        r_state, w_next, w_go;
  logic          r_op, r_err;
  logic [W-1:0]  r_a, r_s, r_y;
  logic [3:0]    r_rule;
  logic [GW-1:0] r_gens;
  logic [CW-1:0] r_cnt;
  logic          w_accept, w_step, w_last_sqm, w_last_ca, w_err;
  logic [PW-1:0] w_p;
  logic [W-1:0]  w_rem, w_y, w_ca_next;
  assign w_accept   = start && (r_state == IDLE || r_state == DONE);
  assign w_step     = r_state == SQM;
  assign w_last_sqm = r_cnt == CW'(PW - 1);
  assign w_last_ca  = r_cnt == CW'(r_gens - 1'b1);
  assign w_p        = PW'(b) * PW'(b);
  assign w_ca_next  = W'(ca_step(CA_MAXW'(r_s), W, r_rule));
  assign w_y        = (r_op == OP_CA) ? r_s : w_rem;
  assign w_err      = (r_op == OP_SQM) && (r_a == '0);
  assign busy       = (r_state == SQM) || (r_state == CA);
  assign done       = r_state == DONE;
  // Result is presented live in the DONE cycle and latched for the idle period after it.
  assign y          = done ? w_y : r_y;
  assign err        = done ? w_err : r_err;
  always_comb begin
    w_go   = (op == OP_SQM) ? ((a != '0) ? SQM : DONE) : ((gens != '0) ? CA : DONE);
    w_next = w_accept ? w_go :
             (r_state == SQM) ? (w_last_sqm ? DONE : SQM) :
             (r_state == CA)  ? (w_last_ca  ? DONE : CA)  : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_SQM;
      r_a     <= '0;
      r_s     <= '0;
      r_rule  <= '0;
      r_gens  <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= op;
        r_a    <= a;
        r_s    <= a;
        r_rule <= b[3:0];
        r_gens <= gens;
        r_cnt  <= '0;
      end else if (busy) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_state == CA) r_s <= w_ca_next;
      end
      if (done) begin
        r_y   <= w_y;
        r_err <= w_err;
      end
    end
  end
  sqm_mod_seq #(.W(W), .PW(PW)) u_mod (
    .clk  (clk),
    .rst  (rst),
    .load (w_accept),
    .p    (w_p),
    .a    (r_a),
    .step (w_step),
    .r    (w_rem)
  );
endmodule
